seg_reduce_pipe: RTL

SEG_REDUCE_PIPE -- requirements
Module: seg_reduce_pipe

---
 rtl/seg_reduce_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg_reduce_pipe.sv
// Segmented sum-reduce with gather: LGN Hillis-Steele scan stages, then a carry/gather stage; SEG_RED_SAT_EN selects saturating adders.
// Latency LGN+1 registered stages, one beat per cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage, the carry and in_ready.
module seg_reduce_pipe #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int LGN = $clog2(N),
    localparam int L = LGN + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0][W-1:0]     in_data,
    input  logic [N-1:0]            in_split,
    input  logic [N-1:0][LGN-1:0]   in_out_idx,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0][W-1:0]     out_data,
    output logic [W-1:0]            out_carry
);

    localparam int NSCAN = L - 1;

    function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEG_RED_SAT_EN
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? '1 : s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [N-1:0][W-1:0]   sum_q   [NSCAN];
    logic [N-1:0][W-1:0]   sum_d   [NSCAN];
    logic [N-1:0]          hd_q    [NSCAN];
    logic [N-1:0]          hd_d    [NSCAN];
    logic [N-1:0][LGN-1:0] idx_q   [NSCAN];
    logic [NSCAN-1:0]      vld_q;
    logic [NSCAN-1:0]      last_q;
    logic [NSCAN-1:0]      slast_q;

    logic [N-1:0][W-1:0]   stg_sum [NSCAN+1];
    logic [N-1:0]          stg_hd  [NSCAN+1];

    logic                  out_vld_q;
    logic [N-1:0][W-1:0]   out_dat_q;
    logic [N-1:0][W-1:0]   out_dat_d;
    logic [W-1:0]          out_car_q;
    logic [W-1:0]          carry_q;
    logic [W-1:0]          carry_d;
    logic [W-1:0]          carry_eff;
    logic [W-1:0]          tail_q;
    logic [W-1:0]          tail_d;
    logic                  clr_q;
    logic                  out_fire;
    logic [N-1:0][W-1:0]   fin;

    assign out_fire  = out_vld_q && out_ready;
    assign in_ready  = !(out_vld_q && !out_ready);
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_carry = out_car_q;

    // hd[i] marks a segment head: lane i-1 closed its segment.
    always_comb begin
        stg_sum[0] = in_data;
        stg_hd[0]  = {in_split[N-2:0], 1'b0};
        for (int s = 0; s < NSCAN; s++) begin
            stg_sum[s+1] = sum_q[s];
            stg_hd[s+1]  = hd_q[s];
        end
    end

    always_comb begin
        for (int s = 0; s < NSCAN; s++) begin
            sum_d[s] = stg_sum[s];
            hd_d[s]  = stg_hd[s];
            for (int i = (1 << s); i < N; i++) begin
                if (!stg_hd[s][i]) begin
                    sum_d[s][i] = add_w(stg_sum[s][i - (1 << s)], stg_sum[s][i]);
                end
                hd_d[s][i] = stg_hd[s][i] | stg_hd[s][i - (1 << s)];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            last_q  <= '0;
            slast_q <= '0;
            for (int s = 0; s < NSCAN; s++) begin
                sum_q[s] <= '0;
                hd_q[s]  <= '0;
                idx_q[s] <= '0;
            end
        end else if (in_ready) begin
            vld_q   <= {vld_q[NSCAN-2:0], in_valid};
            last_q  <= {last_q[NSCAN-2:0], in_last};
            slast_q <= {slast_q[NSCAN-2:0], in_split[N-1]};
            idx_q[0] <= in_out_idx;
            for (int s = 0; s < NSCAN; s++) begin
                sum_q[s] <= sum_d[s];
                hd_q[s]  <= hd_d[s];
            end
            for (int s = 1; s < NSCAN; s++) begin
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    // The beat entering the output register must see the carry left by the beat leaving it this same edge.
    always_comb begin
        carry_d   = clr_q ? '0 : tail_q;
        carry_eff = out_fire ? carry_d : carry_q;
    end

    always_comb begin
        fin       = '0;
        out_dat_d = '0;
        for (int i = 0; i < N; i++) begin
            fin[i] = stg_hd[NSCAN][i] ? stg_sum[NSCAN][i] : add_w(stg_sum[NSCAN][i], carry_eff);
        end
        for (int i = 0; i < N; i++) begin
            out_dat_d[i] = fin[idx_q[NSCAN-1][i]];
        end
        tail_d = fin[N-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_car_q <= '0;
            carry_q   <= '0;
            tail_q    <= '0;
            clr_q     <= 1'b0;
        end else begin
            if (out_fire) begin
                carry_q <= carry_d;
            end
            if (in_ready) begin
                out_vld_q <= vld_q[NSCAN-1];
                out_dat_q <= out_dat_d;
                out_car_q <= carry_eff;
                tail_q    <= tail_d;
                clr_q     <= last_q[NSCAN-1] | slast_q[NSCAN-1];
            end
        end
    end

endmodule
